// File: rtl/fetch_if.sv
// -----------------------------------------------------------------------------
// fetch_if
// Purpose : groups every signal between the instruction-fetch controller and
//           its neighbours (PC register, instruction memory, decode stage and
//           redirect sources) into one bundle.
// Modports:
//   master - the fetch controller: drives PC control, memory request, IR and
//            FAULT; receives PC, memory response, IR_READY and redirects.
//   slave  - the environment around the controller (mirror image of master).
// Signals :
//   pc_in      current PC from the PC register
//   pc_en      PC register enable
//   pc_mode    0 = increment by 4, 1 = load pc_d
//   pc_d       PC load value (0 whenever pc_mode = 0)
//   imem_req   instruction read request, held until imem_ack
//   imem_addr  read address, always equal to pc_in
//   imem_ack   one-cycle read completion strobe
//   imem_data  read data, meaningful only with imem_ack
//   ir         fetched instruction
//   ir_valid   ir holds a valid instruction
//   ir_ready   downstream ready to take ir
//   br_taken   branch redirect pulse, br_target sampled with it
//   br_target  branch redirect target
//   exc        exception redirect pulse
//   fault      one-cycle pulse on misaligned target or fetch timeout
//
// Handshake on ir: the instruction transfers in a cycle where ir_valid = 1 and
// ir_ready = 1. While ir_valid = 1 and ir_ready = 0, ir and ir_valid are held
// stable; ir_valid only drops early when a redirect kills the instruction.
// -----------------------------------------------------------------------------
interface fetch_if;
    logic [31:0] pc_in;
    logic        pc_en;
    logic        pc_mode;
    logic [31:0] pc_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] ir;
    logic        ir_valid;
    logic        ir_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc;
    logic        fault;

    modport master (
        input  pc_in, imem_ack, imem_data, ir_ready, br_taken, br_target, exc,
        output pc_en, pc_mode, pc_d, imem_req, imem_addr, ir, ir_valid, fault
    );

    modport slave (
        output pc_in, imem_ack, imem_data, ir_ready, br_taken, br_target, exc,
        input  pc_en, pc_mode, pc_d, imem_req, imem_addr, ir, ir_valid, fault
    );
endinterface

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Purpose : instruction-fetch sequencer. Requests one instruction at the
//           current PC, captures it into IR, hands it downstream with a
//           valid/ready handshake, and steers the external PC register for
//           sequential flow, branches, exceptions and fetch timeouts.
// Ports   :
//   clk_i          single clock, rising edge
//   res_i          synchronous active-high reset
//   bus            fetch_if.master bundle (PC, IMEM, IR, redirects, FAULT)
//   state_o        current FSM state (0 = BOOT, 1 = FETCH, 2 = ISSUE)
//   pc_at_reset_o  1 when pc_in equals RESET_VECTOR
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h1A000000,
    parameter logic [31:0] EXC_VECTOR   = 32'h1A000100,
    parameter int unsigned ACK_TIMEOUT  = 16
) (
    input  logic       clk_i,
    input  logic       res_i,
    fetch_if.master    bus,
    output logic [1:0] state_o,
    output logic       pc_at_reset_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    localparam logic [4:0] TMO_LIMIT = 5'(ACK_TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic        squash_q, squash_d;
    logic [4:0]  tmo_q, tmo_d;

    logic        active;
    logic        in_fetch;
    logic        timeout;
    logic        br_aligned;
    logic        redirect;
    logic        redir_br;
    logic        fault_w;
    logic        ack_fetch;
    logic [31:0] redir_pc;

    // Redirects are only honoured once out of BOOT and out of reset.
    assign active     = !res_i && (state_q != ST_BOOT);
    assign in_fetch   = active && (state_q == ST_FETCH);
    assign timeout    = in_fetch && (tmo_q == TMO_LIMIT);
    assign br_aligned = (bus.br_target[1:0] == 2'b00);

    // A timeout behaves like an exception; a misaligned branch also lands on
    // the exception vector. Only an aligned branch without EXC uses br_target.
    assign redirect  = active && (bus.exc || bus.br_taken || timeout);
    assign redir_br  = !timeout && !bus.exc && bus.br_taken && br_aligned;
    assign redir_pc  = redir_br ? bus.br_target : EXC_VECTOR;
    assign fault_w   = active && (timeout || (!bus.exc && bus.br_taken && !br_aligned));

    // The request is dropped in the timeout cycle, so an ACK there is ignored.
    assign ack_fetch = in_fetch && bus.imem_ack && !timeout;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i) begin
        if (res_i) begin
            state_q    <= ST_BOOT;
            ir_q       <= 32'h0;
            ir_valid_q <= 1'b0;
            squash_q   <= 1'b0;
            tmo_q      <= 5'd0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            squash_q   <= squash_d;
            tmo_q      <= tmo_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        squash_d   = squash_q;
        tmo_d      = tmo_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                tmo_d   = 5'd0;
            end

            ST_FETCH: begin
                if (timeout) begin
                    // The abandoned request may still be answered later;
                    // squash makes sure that late ACK is thrown away.
                    squash_d   = 1'b1;
                    ir_valid_d = 1'b0;
                    tmo_d      = 5'd0;
                end else if (redirect) begin
                    ir_valid_d = 1'b0;
                    if (bus.imem_ack) begin
                        // Data for the old PC arrives now: drop it, nothing
                        // left outstanding.
                        squash_d = 1'b0;
                        tmo_d    = 5'd0;
                    end else begin
                        squash_d = 1'b1;
                        tmo_d    = 5'(tmo_q + 5'd1);
                    end
                end else if (bus.imem_ack) begin
                    tmo_d = 5'd0;
                    if (squash_q) begin
                        // Stale response; re-issue at the redirected PC.
                        squash_d = 1'b0;
                    end else begin
                        ir_d       = bus.imem_data;
                        ir_valid_d = 1'b1;
                        state_d    = ST_ISSUE;
                    end
                end else begin
                    tmo_d = 5'(tmo_q + 5'd1);
                end
            end

            ST_ISSUE: begin
                tmo_d = 5'd0;
                if (redirect) begin
                    ir_valid_d = 1'b0;
                    state_d    = ST_FETCH;
                end else if (ir_valid_q && bus.ir_ready) begin
                    ir_valid_d = 1'b0;
                    state_d    = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        bus.pc_en     = 1'b0;
        bus.pc_mode   = 1'b0;
        bus.pc_d      = 32'h0;
        bus.imem_req  = in_fetch && !timeout;
        bus.imem_addr = bus.pc_in;
        bus.ir        = ir_q;
        bus.ir_valid  = ir_valid_q;
        bus.fault     = fault_w;

        if (redirect) begin
            bus.pc_en   = 1'b1;
            bus.pc_mode = 1'b1;
            bus.pc_d    = redir_pc;
        end else if (ack_fetch && !squash_q) begin
            bus.pc_en = 1'b1;
        end
    end

    assign state_o       = state_q;
    assign pc_at_reset_o = (bus.pc_in == RESET_VECTOR);

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Purpose : self-checking bench for fetch_ctrl. A small PC register model sits
//           next to the DUT; per-cycle vectors drive the inputs and give the
//           expected outputs, and a scoreboard follows every instruction from
//           accepted ACK to the IR handshake.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam logic [31:0] A0   = 32'h1A000000;
    localparam logic [31:0] EV   = 32'h1A000100;
    localparam logic [31:0] T40  = 32'h1A000040;
    localparam logic [31:0] T42  = 32'h1A000042;
    localparam logic [31:0] T80  = 32'h1A000080;
    localparam logic [31:0] T200 = 32'h1A000200;
    localparam logic [31:0] Z    = 32'h0;
    localparam logic [31:0] BAD  = 32'hBAD0BAD0;
    localparam logic        Y    = 1'b1;
    localparam logic        N    = 1'b0;

    typedef struct {
        logic        ack;
        logic [31:0] data;
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic        exc;
        logic        push;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_en;
        logic        e_mode;
        logic [31:0] e_pcd;
        logic        e_fault;
        logic        e_irv;
        logic [31:0] e_ir;
    } vec_t;

    // ------------------------------------------------ clock / reset / DUT
    logic        clk;
    logic        res;
    logic [1:0]  state_o;
    logic        pc_at_reset_o;
    logic [31:0] pc_model;

    fetch_if bus ();

    fetch_ctrl dut (
        .clk_i         (clk),
        .res_i         (res),
        .bus           (bus),
        .state_o       (state_o),
        .pc_at_reset_o (pc_at_reset_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External PC register, as it sits beside the controller.
    always @(posedge clk) begin
        if (res)
            pc_model <= A0;
        else if (bus.pc_en)
            pc_model <= bus.pc_mode ? bus.pc_d : pc_model + 32'd4;
    end
    assign bus.pc_in = pc_model;

    // --------------------------------------------------- check bookkeeping
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_exp;
    vec_t        vecs[31];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic ack, input logic [31:0] data, input logic rdy,
        input logic br, input logic [31:0] tgt, input logic exc, input logic push,
        input logic e_req, input logic [31:0] e_addr, input logic e_en,
        input logic e_mode, input logic [31:0] e_pcd, input logic e_fault,
        input logic e_irv, input logic [31:0] e_ir);
        vec_t v;
        v.ack = ack;   v.data = data;     v.rdy = rdy;
        v.br = br;     v.tgt = tgt;       v.exc = exc;     v.push = push;
        v.e_req = e_req;   v.e_addr = e_addr; v.e_en = e_en;
        v.e_mode = e_mode; v.e_pcd = e_pcd;   v.e_fault = e_fault;
        v.e_irv = e_irv;   v.e_ir = e_ir;
        return v;
    endfunction

    // ------------------------------------------------------------- driver
    task automatic run_vec(input vec_t v, input logic r, input string tag);
        @(negedge clk);
        res           = r;
        bus.imem_ack  = v.ack;
        bus.imem_data = v.data;
        bus.ir_ready  = v.rdy;
        bus.br_taken  = v.br;
        bus.br_target = v.tgt;
        bus.exc       = v.exc;
        #1;
        chk({tag, ".req"},   32'(bus.imem_req),  32'(v.e_req));
        chk({tag, ".addr"},  bus.imem_addr,      v.e_addr);
        chk({tag, ".pc_en"}, 32'(bus.pc_en),     32'(v.e_en));
        chk({tag, ".mode"},  32'(bus.pc_mode),   32'(v.e_mode));
        chk({tag, ".pc_d"},  bus.pc_d,           v.e_pcd);
        chk({tag, ".fault"}, 32'(bus.fault),     32'(v.e_fault));
        chk({tag, ".irv"},   32'(bus.ir_valid),  32'(v.e_irv));
        chk({tag, ".ir"},    bus.ir,             v.e_ir);
        if (v.push) exp_q.push_back(v.data);
    endtask

    // --------------------------------------------------------- scoreboard
    always begin
        @(negedge clk);
        #2;
        if (!res && bus.ir_valid && bus.ir_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got ir %h expected no instruction", bus.ir);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("sb_ir", bus.ir, sb_exp);
            end
        end
    end

    // -------------------------------------------------------------- tests
    localparam logic [31:0] I0 = 32'h00000013;
    localparam logic [31:0] I1 = 32'h00A00093;
    localparam logic [31:0] I2 = 32'h00208133;
    localparam logic [31:0] I3 = 32'h40110233;
    localparam logic [31:0] I4 = 32'h00000073;
    localparam logic [31:0] I5 = 32'hFE000EE3;
    localparam logic [31:0] I6 = 32'h12345678;
    localparam logic [31:0] I7 = 32'h0C0FFEE3;

    initial begin
        res = 1'b1;
        bus.imem_ack = N;  bus.imem_data = Z;  bus.ir_ready = N;
        bus.br_taken = N;  bus.br_target = Z;  bus.exc = N;

        //        ack data rdy br tgt exc push | req addr      en mode pcd   flt irv ir
        // Sequential fetch, ACK two cycles after the request; ACK in BOOT ignored.
        vecs[0]  = mk(Y, 32'hDEADBEEF, Y, N, Z, N, N,  N, A0,        N, N, Z,    N, N, Z);
        vecs[1]  = mk(N, Z,   Y, N, Z,    N, N,  Y, A0,        N, N, Z,    N, N, Z);
        vecs[2]  = mk(N, Z,   Y, N, Z,    N, N,  Y, A0,        N, N, Z,    N, N, Z);
        vecs[3]  = mk(Y, I0,  Y, N, Z,    N, Y,  Y, A0,        Y, N, Z,    N, N, Z);
        vecs[4]  = mk(N, Z,   Y, N, Z,    N, N,  N, A0 + 4,    N, N, Z,    N, Y, I0);
        vecs[5]  = mk(N, Z,   Y, N, Z,    N, N,  Y, A0 + 4,    N, N, Z,    N, N, I0);
        vecs[6]  = mk(N, Z,   Y, N, Z,    N, N,  Y, A0 + 4,    N, N, Z,    N, N, I0);
        vecs[7]  = mk(Y, I1,  Y, N, Z,    N, Y,  Y, A0 + 4,    Y, N, Z,    N, N, I0);
        vecs[8]  = mk(N, Z,   Y, N, Z,    N, N,  N, A0 + 8,    N, N, Z,    N, Y, I1);
        vecs[9]  = mk(N, Z,   Y, N, Z,    N, N,  Y, A0 + 8,    N, N, Z,    N, N, I1);
        vecs[10] = mk(N, Z,   Y, N, Z,    N, N,  Y, A0 + 8,    N, N, Z,    N, N, I1);
        vecs[11] = mk(Y, I2,  Y, N, Z,    N, N,  Y, A0 + 8,    Y, N, Z,    N, N, I1);
        // Branch while IR waits in ISSUE: instruction killed, fetch at target.
        vecs[12] = mk(N, Z,   N, Y, T40,  N, N,  N, A0 + 12,   Y, Y, T40,  N, Y, I2);
        // Branch during FETCH without ACK: the ACK three cycles later is dropped.
        vecs[13] = mk(N, Z,   Y, Y, T80,  N, N,  Y, T40,       Y, Y, T80,  N, N, I2);
        vecs[14] = mk(N, Z,   Y, N, Z,    N, N,  Y, T80,       N, N, Z,    N, N, I2);
        vecs[15] = mk(N, Z,   Y, N, Z,    N, N,  Y, T80,       N, N, Z,    N, N, I2);
        vecs[16] = mk(Y, BAD, Y, N, Z,    N, N,  Y, T80,       N, N, Z,    N, N, I2);
        vecs[17] = mk(N, Z,   Y, N, Z,    N, N,  Y, T80,       N, N, Z,    N, N, I2);
        vecs[18] = mk(N, Z,   Y, N, Z,    N, N,  Y, T80,       N, N, Z,    N, N, I2);
        vecs[19] = mk(Y, I3,  Y, N, Z,    N, Y,  Y, T80,       Y, N, Z,    N, N, I2);
        vecs[20] = mk(N, Z,   Y, N, Z,    N, N,  N, T80 + 4,   N, N, Z,    N, Y, I3);
        // EXC together with an aligned branch: exception vector, no fault.
        vecs[21] = mk(N, Z,   Y, Y, T40,  Y, N,  Y, T80 + 4,   Y, Y, EV,   N, N, I3);
        vecs[22] = mk(Y, BAD, Y, N, Z,    N, N,  Y, EV,        N, N, Z,    N, N, I3);
        // Misaligned branch target: exception vector plus FAULT.
        vecs[23] = mk(N, Z,   Y, Y, T42,  N, N,  Y, EV,        Y, Y, EV,   Y, N, I3);
        vecs[24] = mk(Y, BAD, Y, N, Z,    N, N,  Y, EV,        N, N, Z,    N, N, I3);
        vecs[25] = mk(Y, I4,  Y, N, Z,    N, Y,  Y, EV,        Y, N, Z,    N, N, I3);
        vecs[26] = mk(N, Z,   Y, N, Z,    N, N,  N, EV + 4,    N, N, Z,    N, Y, I4);
        // Branch in the same cycle as ACK: data dropped, no squash.
        vecs[27] = mk(Y, BAD, Y, Y, T200, N, N,  Y, EV + 4,    Y, Y, T200, N, N, I4);
        vecs[28] = mk(Y, I5,  Y, N, Z,    N, Y,  Y, T200,      Y, N, Z,    N, N, I4);
        vecs[29] = mk(N, Z,   N, N, Z,    N, N,  N, T200 + 4,  N, N, Z,    N, Y, I5);
        vecs[30] = mk(N, Z,   Y, N, Z,    N, N,  N, T200 + 4,  N, N, Z,    N, Y, I5);

        // Reset: outputs quiet, redirects and ACK ignored.
        run_vec(mk(N, Z, N, N, Z, N, N,  N, A0, N, N, Z, N, N, Z), Y, "rst0");
        run_vec(mk(Y, BAD, Y, Y, T40, Y, N,  N, A0, N, N, Z, N, N, Z), Y, "rst1");
        chk("rst.state", 32'(state_o), 32'd0);
        chk("rst.pc_at_reset", 32'(pc_at_reset_o), 32'd1);

        for (int i = 0; i < 31; i++)
            run_vec(vecs[i], N, $sformatf("r%0d", i));
        chk("tbl.pc_at_reset", 32'(pc_at_reset_o), 32'd0);

        // Fetch timeout: 16 FETCH cycles without ACK, then drop + FAULT + EXC.
        for (int k = 0; k < 16; k++)
            run_vec(mk(N, Z, Y, N, Z, N, N,  Y, T200 + 4, N, N, Z, N, N, I5), N,
                    $sformatf("tmo%0d", k));
        run_vec(mk(N, Z, Y, N, Z, N, N,  N, T200 + 4, Y, Y, EV, Y, N, I5), N, "tmo16");
        run_vec(mk(Y, BAD, Y, N, Z, N, N,  Y, EV, N, N, Z, N, N, I5), N, "tmo_late");
        run_vec(mk(Y, I6, Y, N, Z, N, Y,  Y, EV, Y, N, Z, N, N, I5), N, "tmo_refetch");

        // Downstream stall: IR held for 10 cycles, then consumed.
        for (int k = 0; k < 10; k++)
            run_vec(mk(N, Z, N, N, Z, N, N,  N, EV + 4, N, N, Z, N, Y, I6), N,
                    $sformatf("stall%0d", k));
        run_vec(mk(N, Z, Y, N, Z, N, N,  N, EV + 4, N, N, Z, N, Y, I6), N, "stall_go");

        // Reset in the middle of a fetch; ACK in BOOT ignored.
        run_vec(mk(N, Z, Y, N, Z, N, N,  Y, EV + 4, N, N, Z, N, N, I6), N, "mid_fetch");
        run_vec(mk(Y, BAD, Y, Y, T40, Y, N,  N, EV + 4, N, N, Z, N, N, I6), Y, "mid_rst");
        run_vec(mk(Y, BAD, Y, Y, T40, Y, N,  N, A0, N, N, Z, N, N, Z), N, "boot");
        chk("boot.state", 32'(state_o), 32'd0);
        run_vec(mk(N, Z, Y, N, Z, N, N,  Y, A0, N, N, Z, N, N, Z), N, "post_boot");
        chk("post_boot.state", 32'(state_o), 32'd1);
        run_vec(mk(Y, I7, Y, N, Z, N, Y,  Y, A0, Y, N, Z, N, N, Z), N, "post_ack");
        run_vec(mk(N, Z, Y, N, Z, N, N,  N, A0 + 4, N, N, Z, N, Y, I7), N, "post_issue");

        @(negedge clk);
        #3;
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
